sorted_insert_writer: RTL and testbench
=======================================

# sorted_insert_writer

Write-side companion to the binary-search controller: maintains the 32×8 search RAM in ascending order by insertion sort, one value per Start handshake. Each accepted byte is placed in sorted position by shifting larger entries up one address (read-compare-write from the top of the occupied region). The search controller relies on the ordering and on `Count` for its initial upper bound. The writer owns the single RAM port while `Busy` is high.

## Interface
- No parameters; depth is fixed at 32 entries and width at 8 bits.
- `Clock`  in  1  sole clock; all state changes on the rising edge.
- `Resetn`  in  1  asynchronous, active-low reset.
- `Start`  in  1  level request to insert `Data_In`.
- `Clear`  in  1  empties the list; honoured only in IDLE and takes priority over `Start`.
- `Data_In`  in  8  value to insert; sampled on the edge that leaves IDLE.
- `Ram_Rd_Data`  in  8  RAM read data, valid the cycle after the address is presented (synchronous read).
- `Ram_Addr`  out  5  RAM address.
- `Ram_Wr_Data`  out  8  RAM write data.
- `Ram_Wren`  out  1  RAM write enable.
- `Count`  out  6  number of valid entries, 0–32.
- `Full`  out  1  `Count == 32`.
- `Busy`  out  1  high in READ, CMP and PLACE.
- `Done`  out  1  high in DONE.
- `Reject`  out  1  high in DONE when the request arrived while `Full`.

## Operation
- Registers:
  - `D` (8 bits): captured value.
  - `idx` (6 bits): current hole position.
  - `Count` (6 bits).
  - state.
- IDLE: `Ram_Wren` = 0 and `Ram_Addr` = 0.
  - `Clear`=1: `Count` ← 0 and stay in IDLE. RAM contents are untouched.
  - else `Start`=1 with `Full`: `Reject` ← 1 and go to DONE. No RAM write.
  - else `Start`=1: `D` ← `Data_In`, `idx` ← `Count`, `Reject` ← 0. Go to PLACE if `Count`==0, otherwise to READ.
- READ: `Ram_Addr` = `idx`−1, no write. Go to CMP.
- CMP: `Ram_Rd_Data` holds entry `idx`−1.
  - `Ram_Rd_Data` > `D` (unsigned): write the entry up one slot (`Ram_Addr` = `idx`, `Ram_Wr_Data` = `Ram_Rd_Data`, `Ram_Wren` = 1), then `idx` ← `idx`−1. Go to PLACE if the new `idx` is 0, otherwise to READ.
  - else: no write; go to PLACE. Equal values stop the scan, so the new entry lands above existing duplicates.
- PLACE: `Ram_Addr` = `idx`, `Ram_Wr_Data` = `D`, `Ram_Wren` = 1, `Count` ← `Count`+1. Go to DONE.
- DONE: hold while `Start`=1, so a held Start produces exactly one insertion. Return to IDLE when `Start`=0.
- `Ram_Wr_Data` equals `D` in every state except CMP.
- `Clear`, `Start` and `Data_In` are ignored outside IDLE, apart from the `Start` check in DONE.
- `Count` never exceeds 32, and `idx` never underflows (it stops at 0).

## Timing
- Reset values (asynchronous, immediate):
  - state IDLE; `D`=0, `idx`=0, `Count`=0.
  - `Full`, `Busy`, `Done`, `Reject` and `Ram_Wren` all 0; `Ram_Addr`=0; `Ram_Wr_Data`=0.
- All outputs are decoded from registered state, so there are no combinational paths from `Start` or `Data_In` to outputs. In CMP only, `Ram_Wr_Data` and `Ram_Wren` depend on `Ram_Rd_Data`.
- Latency, counted from the edge that samples `Start` in IDLE, with n = `Count` and k = entries shifted:
  - `Done` rises after 2k + 2·[k<n] + 2 edges.
  - Insert into empty: 2 cycles.
  - Insert into n entries with no shift: 4 cycles.
  - Worst case (n=31, k=31): 64 cycles.
- Reject path: `Done` and `Reject` rise 1 cycle after `Start` is sampled.
- RAM write timing: each shift write lands on the edge ending CMP, and the PLACE write on the edge ending PLACE. `Count` updates on that same PLACE edge.
- Reset mid-operation: the block returns to IDLE with `Count`=0. Any partially shifted RAM contents are meaningless and are not repaired.

## Test plan
- Reset, then insert 10 → one write, `Ram_Addr`=0 data 10. `Count`=1 and `Done`=1 two cycles after Start. `Done` stays high until Start drops.
- Insert 10, 30, 20 in that order → RAM[0..2] = 10, 20, 30 and `Count`=3. The insert of 20 shifts one entry: `Done` at 2+2+2 = 6 cycles.
- With 10, 20, 30 present, insert 5 → three shifts, RAM[0..3] = 5, 10, 20, 30, `Done` after 8 cycles. Insert 20 → no shift past the existing 20; RAM = 5, 10, 20, 20, 30.
- Insert 32 ascending values, then insert 0 → `Full`=1, `Done` and `Reject` after 1 cycle, no `Ram_Wren` pulse, `Count` stays 32. Then `Clear` in IDLE → `Count`=0 and `Full`=0.
- Hold Start high for 20 cycles after one insert → `Count` increments exactly once.
- Assert `Resetn`=0 during CMP of a 3-shift insert → all outputs go to their reset values immediately, `Count`=0, and the next insert of 7 is written to address 0.

Source files
------------

// File: rtl/sorted_insert_writer_if.sv
// Handshake and RAM-port bundle between the sorted-insert writer and its environment.
interface sorted_insert_writer_if;
    logic       start;
    logic       clear;
    logic [7:0] data_in;
    logic [7:0] ram_rd_data;
    logic [4:0] ram_addr;
    logic [7:0] ram_wr_data;
    logic       ram_wren;
    logic [5:0] count;
    logic       full;
    logic       busy;
    logic       done;
    logic       reject;

    modport master (
        output start, clear, data_in, ram_rd_data,
        input  ram_addr, ram_wr_data, ram_wren, count, full, busy, done, reject
    );

    modport slave (
        input  start, clear, data_in, ram_rd_data,
        output ram_addr, ram_wr_data, ram_wren, count, full, busy, done, reject
    );
endinterface

// File: rtl/sorted_insert_writer.sv
// Keeps a 32x8 RAM in ascending order: each accepted byte is insertion-sorted in by
// shifting larger entries up one slot, scanning down from the top of the occupied region.
module sorted_insert_writer (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    sorted_insert_writer_if.slave        bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_CMP   = 3'd2,
        S_PLACE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] d_q, d_d;
    logic [5:0] idx_q, idx_d;
    logic [5:0] count_q, count_d;
    logic       reject_q, reject_d;

    logic       full_s;
    logic       shift_s;
    logic [4:0] ram_addr_s;
    logic [7:0] ram_wr_data_s;
    logic       ram_wren_s;

    assign full_s  = (count_q == 6'd32);
    // idx is never 0 in CMP, but the guard keeps the hole from wrapping regardless
    assign shift_s = (bus.ram_rd_data > d_q) && (idx_q != 6'd0);

    // Next-state and datapath register updates
    always_comb begin
        state_d  = state_q;
        d_d      = d_q;
        idx_d    = idx_q;
        count_d  = count_q;
        reject_d = reject_q;
        case (state_q)
            S_IDLE: begin
                if (bus.clear) begin
                    count_d = 6'd0;
                end else if (bus.start && full_s) begin
                    reject_d = 1'b1;
                    state_d  = S_DONE;
                end else if (bus.start) begin
                    d_d      = bus.data_in;
                    idx_d    = count_q;
                    reject_d = 1'b0;
                    state_d  = (count_q == 6'd0) ? S_PLACE : S_READ;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_READ: begin
                state_d = S_CMP;
            end
            S_CMP: begin
                if (shift_s) begin
                    idx_d   = idx_q - 6'd1;
                    state_d = (idx_q == 6'd1) ? S_PLACE : S_READ;
                end else begin
                    state_d = S_PLACE;
                end
            end
            S_PLACE: begin
                if (!full_s) begin
                    count_d = count_q + 6'd1;
                end else begin
                    count_d = count_q;
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                if (bus.start) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            d_q      <= 8'd0;
            idx_q    <= 6'd0;
            count_q  <= 6'd0;
            reject_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            d_q      <= d_d;
            idx_q    <= idx_d;
            count_q  <= count_d;
            reject_q <= reject_d;
        end
    end

    // RAM port decode; only CMP looks at read data
    always_comb begin
        ram_addr_s    = 5'd0;
        ram_wr_data_s = d_q;
        ram_wren_s    = 1'b0;
        case (state_q)
            S_READ: begin
                ram_addr_s = idx_q[4:0] - 5'd1;
            end
            S_CMP: begin
                ram_addr_s    = idx_q[4:0];
                ram_wr_data_s = bus.ram_rd_data;
                ram_wren_s    = shift_s;
            end
            S_PLACE: begin
                ram_addr_s = idx_q[4:0];
                ram_wren_s = 1'b1;
            end
            default: begin
                ram_addr_s = 5'd0;
            end
        endcase
    end

    assign bus.ram_addr    = ram_addr_s;
    assign bus.ram_wr_data = ram_wr_data_s;
    assign bus.ram_wren    = ram_wren_s;
    assign bus.count       = count_q;
    assign bus.full        = full_s;
    assign bus.busy        = (state_q == S_READ) || (state_q == S_CMP) || (state_q == S_PLACE);
    assign bus.done        = (state_q == S_DONE);
    assign bus.reject      = (state_q == S_DONE) && reject_q;

endmodule

// File: tb/tb_sorted_insert_writer.sv
// Directed bench for sorted_insert_writer with a synchronous-read RAM model.
module tb_sorted_insert_writer;

    logic clk;
    logic rst_n;
    logic [7:0] ram_m [32];
    int n_cmp;
    int n_fail;
    int wr_cnt;

    sorted_insert_writer_if bus ();

    sorted_insert_writer dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read RAM and write-pulse counter
    always @(posedge clk) begin
        if (bus.ram_wren) begin
            ram_m[bus.ram_addr] <= bus.ram_wr_data;
        end
        bus.ram_rd_data <= ram_m[bus.ram_addr];
        if (rst_n && bus.ram_wren) begin
            wr_cnt <= wr_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_insert(input logic [7:0] v, input int exp_lat, input int exp_wr,
                             input logic exp_rej, input int hold);
        int w0;
        int lat;
        w0 = wr_cnt;
        bus.data_in = v;
        bus.start = 1'b1;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!bus.done && lat < 100);
        check("latency", lat, exp_lat);
        check("writes", wr_cnt - w0, exp_wr);
        check("reject", bus.reject, exp_rej);
        if (hold > 0) begin
            repeat (hold) @(posedge clk);
            #1;
            check("hold_done", bus.done, 1'b1);
            check("hold_writes", wr_cnt - w0, exp_wr);
        end
        bus.start = 1'b0;
        @(posedge clk); #1;
        check("done_drop", bus.done, 1'b0);
    endtask

    task automatic do_clear();
        bus.clear = 1'b1;
        @(posedge clk); #1;
        bus.clear = 1'b0;
        check("clear_count", bus.count, 6'd0);
        check("clear_full", bus.full, 1'b0);
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        wr_cnt = 0;
        for (int i = 0; i < 32; i++) ram_m[i] = 8'hFF;
        bus.start = 1'b0;
        bus.clear = 1'b0;
        bus.data_in = 8'd0;
        bus.ram_rd_data = 8'd0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_count", bus.count, 6'd0);
        check("rst_full", bus.full, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check("rst_reject", bus.reject, 1'b0);
        check("rst_wren", bus.ram_wren, 1'b0);
        check("rst_addr", bus.ram_addr, 5'd0);
        check("rst_wdata", bus.ram_wr_data, 8'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Empty insert, Start held for 20 cycles
        do_insert(8'd10, 2, 1, 1'b0, 20);
        check("ins10_ram0", ram_m[0], 8'd10);
        check("ins10_count", bus.count, 6'd1);

        do_insert(8'd30, 4, 1, 1'b0, 0);
        do_insert(8'd20, 6, 2, 1'b0, 0);
        check("ram0_a", ram_m[0], 8'd10);
        check("ram1_a", ram_m[1], 8'd20);
        check("ram2_a", ram_m[2], 8'd30);
        check("count3", bus.count, 6'd3);

        do_insert(8'd5, 8, 4, 1'b0, 0);
        do_insert(8'd20, 6, 2, 1'b0, 0);
        check("ram0_b", ram_m[0], 8'd5);
        check("ram1_b", ram_m[1], 8'd10);
        check("ram2_b", ram_m[2], 8'd20);
        check("ram3_b", ram_m[3], 8'd20);
        check("ram4_b", ram_m[4], 8'd30);
        check("count5", bus.count, 6'd5);

        // Fill to 32, then a rejected insert
        do_clear();
        for (int i = 0; i < 32; i++) begin
            do_insert(8'(i * 8), (i == 0) ? 2 : 4, 1, 1'b0, 0);
        end
        check("full_flag", bus.full, 1'b1);
        check("full_count", bus.count, 6'd32);
        check("ram31_full", ram_m[31], 8'd248);
        check("ram16_full", ram_m[16], 8'd128);
        do_insert(8'd0, 1, 0, 1'b1, 0);
        check("rej_count", bus.count, 6'd32);
        check("rej_ram0", ram_m[0], 8'd0);
        do_clear();

        // Reset during CMP of a 3-shift insert
        do_insert(8'd10, 2, 1, 1'b0, 0);
        do_insert(8'd20, 4, 1, 1'b0, 0);
        do_insert(8'd30, 4, 1, 1'b0, 0);
        bus.data_in = 8'd5;
        bus.start = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("mid_busy", bus.busy, 1'b1);
        bus.start = 1'b0;
        rst_n = 1'b0;
        #1;
        check("mid_rst_count", bus.count, 6'd0);
        check("mid_rst_busy", bus.busy, 1'b0);
        check("mid_rst_done", bus.done, 1'b0);
        check("mid_rst_wren", bus.ram_wren, 1'b0);
        check("mid_rst_addr", bus.ram_addr, 5'd0);
        check("mid_rst_wdata", bus.ram_wr_data, 8'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_insert(8'd7, 2, 1, 1'b0, 0);
        check("post_rst_ram0", ram_m[0], 8'd7);
        check("post_rst_count", bus.count, 6'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
